// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU widths, control codes and result-skid state encoding
package alu_pkg;
  localparam int ALU_DATA_W = 16;
  typedef enum logic [2:0] {
    ALU_AND = 3'd0,
    ALU_OR  = 3'd1,
    ALU_ADD = 3'd2,
    ALU_SUB = 3'd3,
    ALU_SL  = 3'd4,
    ALU_SRL = 3'd5,
    ALU_SRA = 3'd6,
    ALU_SLT = 3'd7
  } alu_op_t;
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_state_t;
endpackage

// File: rtl/alu_pipe_entry.sv
// alu_pipe_entry: load-enabled, synchronously clearable {result, is_zero, tag} register
module alu_pipe_entry #(
  parameter int W = 21
) (
  input  logic         clock,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clock)
    if (clear) q <= '0;
    else if (load) q <= d;
endmodule

// File: rtl/alu_result_skid.sv
// alu_result_skid: 2-entry skid buffer on the ALU result; in_ready is decoded from state only.
// Optional ALU_OUT_STALL_CNT_EN adds a saturating stall_count of out_valid & ~out_ready cycles.
module alu_result_skid
  import alu_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W,
  parameter int TAG_W  = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_result,
  input  logic              in_is_zero,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic              out_is_zero,
  output logic [TAG_W-1:0]  out_tag
`ifdef ALU_OUT_STALL_CNT_EN
  ,
  output logic [15:0]       stall_count
`endif
);
  localparam int EW = DATA_W + 1 + TAG_W;
  skid_state_t state, state_next;
  logic load_main, load_skid, in_fire, out_fire;
  logic [EW-1:0] in_word, main_d, main_q, skid_q;
  assign in_word = {in_result, in_is_zero, in_tag};
  assign in_ready = state != FULL;
  assign out_valid = state != EMPTY;
  assign in_fire = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  assign {out_result, out_is_zero, out_tag} = main_q;
  always_ff @(posedge clock)
    state <= reset ? EMPTY : state_next;
  always_comb begin
    state_next = state;
    load_main = 1'b0;
    load_skid = 1'b0;
    main_d = in_word;
    case (state)
      EMPTY: if (in_fire) begin
        load_main = 1'b1;
        state_next = ONE;
      end
      ONE: begin
        load_main = in_fire & out_fire;
        load_skid = in_fire & ~out_fire;
        state_next = in_fire ? (out_fire ? ONE : FULL) : (out_fire ? EMPTY : ONE);
      end
      FULL: if (out_fire) begin
        load_main = 1'b1;
        main_d = skid_q;
        state_next = ONE;
      end
      default: state_next = EMPTY;
    endcase
    // flush drops both entries and whatever is being offered this cycle
    if (flush) begin
      state_next = EMPTY;
      load_main = 1'b0;
      load_skid = 1'b0;
    end
  end
  alu_pipe_entry #(.W(EW)) u_main (
    .clock(clock), .clear(reset), .load(load_main), .d(main_d), .q(main_q)
  );
  alu_pipe_entry #(.W(EW)) u_skid (
    .clock(clock), .clear(reset), .load(load_skid), .d(in_word), .q(skid_q)
  );
`ifdef ALU_OUT_STALL_CNT_EN
  always_ff @(posedge clock)
    if (reset) stall_count <= '0;
    else if (out_valid & ~out_ready & (stall_count != 16'hFFFF)) stall_count <= stall_count + 16'd1;
`endif
endmodule

// File: tb/tb_alu_result_skid.sv
// tb_alu_result_skid: directed self-checking bench for alu_result_skid
module tb_alu_result_skid;
  logic clock = 1'b0;
  logic reset, flush, in_valid, in_is_zero, out_ready;
  logic in_ready, out_valid, out_is_zero;
  logic [15:0] in_result, out_result;
  logic [3:0] in_tag, out_tag;
  int checks = 0;
  int errors = 0;
`ifdef ALU_OUT_STALL_CNT_EN
  logic [15:0] stall_count;
`endif
  always #5 clock = ~clock;
  alu_result_skid dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_is_zero(in_is_zero), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_is_zero(out_is_zero), .out_tag(out_tag)
`ifdef ALU_OUT_STALL_CNT_EN
    , .stall_count(stall_count)
`endif
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  task automatic drive(input logic v, input logic [15:0] r, input logic z, input logic [3:0] t);
    in_valid = v;
    in_result = r;
    in_is_zero = z;
    in_tag = t;
  endtask
  initial begin
    reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 16'h0, 1'b0, 4'h0);
    step(); step();
    reset = 1'b0;
    step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_result", out_result, 16'h0000);
    chk("rst_out_tag", out_tag, 0);
    chk("rst_out_is_zero", out_is_zero, 0);
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 16'(i), 1'b0, 4'(i));
      chk("stream_in_ready", in_ready, 1);
      step();
      chk("stream_valid", out_valid, 1);
      chk("stream_result", out_result, i);
      chk("stream_tag", out_tag, i);
    end
    drive(1'b0, 16'h0, 1'b0, 4'h0);
    step();
    chk("stream_drained", out_valid, 0);
    out_ready = 1'b0;
    drive(1'b1, 16'h1234, 1'b0, 4'd3);
    step();
    drive(1'b1, 16'hABCD, 1'b0, 4'd5);
    step();
    chk("full_in_ready", in_ready, 0);
    chk("full_out_result", out_result, 16'h1234);
    drive(1'b1, 16'h5555, 1'b0, 4'd7);
    step(); step();
    chk("full_hold_in_ready", in_ready, 0);
    chk("full_hold_result", out_result, 16'h1234);
    chk("full_hold_tag", out_tag, 3);
    out_ready = 1'b1;
    step();
    chk("drain1_result", out_result, 16'hABCD);
    chk("drain1_tag", out_tag, 5);
    step();
    chk("drain2_result", out_result, 16'h5555);
    chk("drain2_tag", out_tag, 7);
    drive(1'b0, 16'h0, 1'b0, 4'h0);
    step();
    chk("drain_empty", out_valid, 0);
    reset = 1'b1; out_ready = 1'b0;
    step();
    reset = 1'b0;
    drive(1'b1, 16'h0000, 1'b1, 4'd9);
    step();
    drive(1'b0, 16'h0, 1'b0, 4'h0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("zero_valid", out_valid, 1);
      chk("zero_flag", out_is_zero, 1);
      chk("zero_result", out_result, 16'h0000);
      chk("zero_tag", out_tag, 9);
    end
`ifdef ALU_OUT_STALL_CNT_EN
    chk("stall_count", stall_count, 4);
`endif
    out_ready = 1'b1;
    step();
    chk("zero_drained", out_valid, 0);
    out_ready = 1'b0;
    drive(1'b1, 16'h1111, 1'b0, 4'd1);
    step();
    drive(1'b1, 16'h2222, 1'b0, 4'd2);
    step();
    chk("pre_flush_full", in_ready, 0);
    flush = 1'b1;
    drive(1'b1, 16'h7777, 1'b0, 4'd6);
    step();
    flush = 1'b0;
    drive(1'b0, 16'h0, 1'b0, 4'h0);
    chk("flush_out_valid", out_valid, 0);
    chk("flush_in_ready", in_ready, 1);
    chk("flush_keeps_main", out_result, 16'h1111);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("flush_no_7777", out_valid, 0);
    end
`ifdef ALU_OUT_STALL_CNT_EN
    chk("stall_after_flush", stall_count, 6);
`endif
    out_ready = 1'b0;
    drive(1'b1, 16'h3333, 1'b0, 4'd3);
    step();
    drive(1'b1, 16'h4444, 1'b0, 4'd4);
    step();
    chk("pre_reset_full", in_ready, 0);
    reset = 1'b1;
    drive(1'b1, 16'h9999, 1'b1, 4'hF);
    for (int i = 0; i < 2; i++) begin
      out_ready = ~out_ready;
      step();
    end
    reset = 1'b0;
    drive(1'b0, 16'h0, 1'b0, 4'h0);
    out_ready = 1'b0;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_result", out_result, 0);
    chk("reset_tag", out_tag, 0);
    chk("reset_is_zero", out_is_zero, 0);
`ifdef ALU_OUT_STALL_CNT_EN
    chk("reset_stall", stall_count, 0);
`endif
    step();
    chk("reset_idle", out_valid, 0);
    drive(1'b1, 16'h00FF, 1'b0, 4'd2);
    step();
    drive(1'b0, 16'h0, 1'b0, 4'h0);
    chk("single_valid", out_valid, 1);
    chk("single_result", out_result, 16'h00FF);
    out_ready = 1'b1;
    step();
    chk("single_alone", out_valid, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
